// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Accepts one command on a valid/ready handshake and runs it as an APB
// SETUP/ACCESS transfer. The result is returned on a response handshake.
// A wait-state timeout stops a hung slave from stalling the requester.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
    // Count value seen on the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    error_q;
    logic                    timeout_q;
    logic                    timeout_hit;

    // The final permitted wait cycle with PREADY still low aborts the transfer.
    // PREADY high on that same cycle completes the transfer normally.
    assign timeout_hit = TO_EN && (state_q == ACCESS) && !PREADY && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid)             state_d = SETUP;
            SETUP:                              state_d = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready)             state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state only. cmd_ready is also masked while reset is held.
    always_comb begin
        cmd_ready = (state_q == IDLE) && !RST;
        PSEL      = (state_q == SETUP) || (state_q == ACCESS);
        PENABLE   = (state_q == ACCESS);
        rsp_valid = (state_q == RESP);
    end

    // Command capture and wait counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (state_q == SETUP)
                cnt_q <= '0;
            else if (state_q == ACCESS && !PREADY && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Response registers are loaded only when ACCESS ends.
    // They stay stable through RESP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (state_q == ACCESS) begin
            if (PREADY) begin
                rdata_q   <= write_q ? '0 : PRDATA;
                error_q   <= PSLVERR;
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                rdata_q   <= '0;
                error_q   <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end

    assign PWRITE      = write_q;
    assign PADDR       = addr_q;
    assign PWDATA      = wdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_error   = error_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master. A directed sequence runs first, followed by randomized transfers.
// Each transfer is checked against a transaction-level model of the expected response and ACCESS length.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            access;
    } rsp_t;

    // A slave that needs 'waits' stall cycles either completes after waits+1 ACCESS cycles or is cut off after TO cycles.
    function automatic rsp_t model(input logic wr, input int waits,
                                   input logic [DW-1:0] prd, input logic perr);
        rsp_t r;
        if (TO != 0 && waits >= TO) begin
            r.rdata = '0; r.err = 1'b1; r.to = 1'b1; r.access = TO;
        end else begin
            r.rdata = wr ? '0 : prd; r.err = perr; r.to = 1'b0; r.access = waits + 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_psel"}, PSEL, 1'b0);
        chk1({tag, "_penable"}, PENABLE, 1'b0);
        chk1({tag, "_pwrite"}, PWRITE, 1'b0);
        chk({tag, "_paddr"}, PADDR, '0);
        chk({tag, "_pwdata"}, PWDATA, '0);
        chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, '0);
        chk1({tag, "_rsp_error"}, rsp_error, 1'b0);
        chk1({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
        chk1({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    endtask

    // The task starts and ends 1 time unit after a rising edge while the DUT is idle.
    // 'waits' is the number of PREADY-low ACCESS cycles. 'hold' is the number of extra RESP cycles with rsp_ready low.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] prd, input logic perr, input int hold);
        rsp_t m;
        m = model(wr, waits, prd, perr);
        chk1("idle_cmd_ready", cmd_ready, 1'b1);
        chk1("idle_psel", PSEL, 1'b0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        step;
        // SETUP: command inputs change to unrelated values to confirm they were captured.
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        chk1("setup_psel", PSEL, 1'b1);
        chk1("setup_penable", PENABLE, 1'b0);
        chk1("setup_pwrite", PWRITE, wr);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwdata", PWDATA, wdata);
        chk1("setup_cmd_ready", cmd_ready, 1'b0);
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        for (int k = 0; k < m.access; k++) begin
            step;
            chk1("access_psel", PSEL, 1'b1);
            chk1("access_penable", PENABLE, 1'b1);
            chk("access_paddr", PADDR, addr);
            chk("access_pwdata", PWDATA, wdata);
            chk1("access_pwrite", PWRITE, wr);
            chk1("access_rsp_valid", rsp_valid, 1'b0);
            PREADY  = (k == waits);
            PRDATA  = (k == waits) ? prd : $urandom;
            PSLVERR = (k == waits) ? perr : 1'($urandom);
        end
        step;
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) step;
            chk1("resp_valid", rsp_valid, 1'b1);
            chk("resp_rdata", rsp_rdata, m.rdata);
            chk1("resp_error", rsp_error, m.err);
            chk1("resp_timeout", rsp_timeout, m.to);
            chk1("resp_psel", PSEL, 1'b0);
            chk1("resp_penable", PENABLE, 1'b0);
            chk1("resp_cmd_ready", cmd_ready, 1'b0);
            rsp_ready = (h == hold);
        end
        step;
        rsp_ready = 1'b0; PREADY = 1'b0;
        chk1("done_rsp_valid", rsp_valid, 1'b0);
        chk1("done_cmd_ready", cmd_ready, 1'b1);
        chk1("done_psel", PSEL, 1'b0);
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        step;
        step;
        chk_reset_vals("reset");
        RST = 1'b0;
        #1;
        chk1("release_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write.
        xfer(1'b1, 32'h0000_0004, 32'hA5A5_1234, 0, 32'h0, 1'b0, 0);
        // Wait-state read: three PREADY-low ACCESS cycles.
        xfer(1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0);
        // Slave error on a read.
        xfer(1'b0, 32'h0000_0020, 32'h0, 0, 32'h1111_1111, 1'b1, 0);
        // Timeout: PREADY never rises.
        xfer(1'b0, 32'h0000_0030, 32'h0, 100, 32'h2222_2222, 1'b0, 0);
        // PREADY rises on the 16th ACCESS cycle and wins over the timeout.
        xfer(1'b0, 32'h0000_0034, 32'h0, TO - 1, 32'h3333_3333, 1'b0, 0);
        // Backpressure: rsp_ready stays low for 5 cycles, then the next command follows back to back.
        xfer(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h0, 1'b0, 5);
        xfer(1'b0, 32'h0000_0044, 32'h1234_5678, 0, 32'h4444_4444, 1'b0, 0);

        // Reset asserted during an ACCESS wait state.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050; cmd_wdata = 32'h5555_5555;
        step;
        cmd_valid = 1'b0; PREADY = 1'b0;
        step;
        step;
        chk1("midrst_penable", PENABLE, 1'b1);
        RST = 1'b1;
        step;
        chk_reset_vals("midrst");
        RST = 1'b0;
        #1;
        chk1("midrst_release_ready", cmd_ready, 1'b1);
        xfer(1'b0, 32'h0000_0054, 32'h0, 2, 32'h6666_6666, 1'b0, 1);

        // Randomized transfers.
        for (int i = 0; i < 24; i++) begin
            xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 20)),
                 $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
